mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the single CPU-side port of the memory controller between instruction fetch (channel 0) and load/store (channel 1). It sits between the cpu core and memory_controller. It accepts packed two-channel requests and serializes them into one outstanding downstream transaction at a time. It routes the completion pulse and read data back to the requester that was granted.

## Interface
- ADDR_W, 32, address width per channel
- DATA_W, 32, data width per channel

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_rw_flag_i  in  4  per channel {ch1,ch0}, 2 bits each: 00 idle, 01 read, 10 write, 11 treated as idle
- req_addr_i  in  2*ADDR_W  per-channel address
- req_w_data_i  in  2*DATA_W  per-channel write data
- req_w_mask_i  in  8  per-channel byte-enable mask, 4 bits each
- req_r_data_o  out  2*DATA_W  per-channel read data, valid while req_done_o of that channel is 1
- req_busy_o  out  2  per channel: arbiter not in IDLE
- req_done_o  out  2  per channel: one-cycle completion pulse
- mem_rw_flag_o  out  2  downstream command, asserted for exactly one cycle per transaction
- mem_addr_o  out  ADDR_W  downstream address
- mem_w_data_o  out  DATA_W  downstream write data
- mem_w_mask_o  out  4  downstream byte mask
- mem_r_data_i  in  DATA_W  downstream read data, valid with mem_done_i
- mem_busy_i  in  1  downstream cannot accept a command this cycle
- mem_done_i  in  1  downstream completion pulse

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. At most one transaction is in flight.
- IDLE: if any channel has flag 01 or 10, arbitrate. Latch the winner's index, flag, addr, w_data and w_mask into registers, then go to ISSUE. With no request, stay in IDLE.
- Arbitration policy: see Configuration. The losing channel keeps its request asserted and is served in a later IDLE.
- ISSUE: if mem_busy_i=0, drive the latched flag, addr, data and mask on mem_* for this cycle and go to WAIT. If mem_busy_i=1, keep mem_rw_flag_o=00 and stay in ISSUE.
- WAIT: on mem_done_i=1, latch mem_r_data_i into the response register and go to RESP.
- RESP: pulse req_done_o[grant]=1 and drive req_r_data_o for the granted channel from the response register, then return to IDLE. The other channel's r_data reads 0.
- For a write, the response register still captures mem_r_data_i, and requesters ignore it.
- Requester contract:
  - Hold flag, addr, data and mask stable until done is seen.
  - Drop or replace the request at the clock edge that ends the done cycle.
- The latched copy is used downstream, so requester changes after IDLE do not affect the in-flight transaction.
- mem_done_i in IDLE, ISSUE or RESP is ignored.
- req_busy_o = {2{state != IDLE}}.
- rst (synchronous) forces IDLE from any state. Any in-flight downstream transaction is abandoned, and its later done is ignored under the IDLE rule.

## Timing
- Reset values:
  - state=IDLE
  - mem_rw_flag_o=00; mem_addr_o, mem_w_data_o and mem_w_mask_o = 0
  - req_done_o=00, req_busy_o=00, req_r_data_o=0
  - last-grant register=1
- Request seen in IDLE at cycle N:
  - ISSUE at N+1, with the mem command in N+1 if not busy
  - WAIT from N+2
  - done at cycle D gives RESP and req_done_o at D+1
  - IDLE at D+2
- Minimum request-to-done: 3 cycles, with the downstream done at N+2.
- Back-to-back: a request held through RESP is re-arbitrated in the IDLE cycle following RESP. This gives one idle bubble per transaction.
- mem_* data outputs are registered and change only on the IDLE→ISSUE transition.
- mem_rw_flag_o is nonzero only in the single ISSUE cycle with mem_busy_i=0.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On a simultaneous request, grant the channel not recorded in the last-grant register.
  - The register updates on every grant.
  - Reset value 1 means channel 0 wins the first tie.
- MEM_ARB_RR_EN undefined: fixed priority, channel 1 (data) always wins a tie. The last-grant register is not built.
- Single-requester behaviour is identical in both builds.

## Test plan
- Ch0 read 0x100, downstream done at N+2 with data 0xDEADBEEF -> mem_rw_flag_o=01 with addr 0x100 for one cycle at N+1; req_done_o=01 and req_r_data_o[31:0]=0xDEADBEEF at N+3.
- Ch1 write 0x200/0x12345678, mask 0011, while mem_busy_i=1 for 3 cycles -> mem_rw_flag_o stays 00 while busy, then 10 for exactly one cycle with the latched addr/data/mask; req_done_o=10 after done.
- Both channels hold read requests continuously for 4 transactions -> grants 1,1,1,1 without RR_EN; grants 0,1,0,1 with MEM_ARB_RR_EN.
- Ch0 read in WAIT, rst asserted for one cycle, then a spurious mem_done_i -> all outputs return to reset values and no req_done_o pulse occurs.
- Requester changes addr from 0x100 to 0x300 one cycle after the grant -> mem_addr_o still 0x100.
- Flag 11 on ch0 with ch1 idle -> arbiter stays in IDLE, req_busy_o=00, no mem command.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single CPU-side port of the memory controller between
// instruction fetch (channel 0) and load/store (channel 1). At most one
// downstream transaction is in flight. The winning request is copied into
// local registers when it is granted, so later requester changes do not
// disturb the in-flight transaction. The completion pulse and read data are
// routed back to the granted channel only.
//
// Build option:
//   MEM_ARB_RR_EN defined   : round-robin on a tie (last-grant register kept,
//                             resets to 1 so channel 0 wins the first tie)
//   MEM_ARB_RR_EN undefined : fixed priority, channel 1 wins every tie
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   req_rw_flag_i   {ch1,ch0} 2-bit commands: 00 idle, 01 read, 10 write,
//                   11 idle
//   req_addr_i      {ch1,ch0} addresses
//   req_w_data_i    {ch1,ch0} write data
//   req_w_mask_i    {ch1,ch0} byte-enable masks
//   req_r_data_o    {ch1,ch0} read data, valid with that channel's done
//   req_busy_o      both bits set whenever the arbiter is not idle
//   req_done_o      one-cycle completion pulse for the granted channel
//   mem_rw_flag_o   downstream command, nonzero for one cycle per transaction
//   mem_addr_o      downstream address (registered)
//   mem_w_data_o    downstream write data (registered)
//   mem_w_mask_o    downstream byte mask (registered)
//   mem_r_data_i    downstream read data, valid with mem_done_i
//   mem_busy_i      downstream cannot take a command this cycle
//   mem_done_i      downstream completion pulse
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req_rw_flag_i,
  input  logic [2*ADDR_W-1:0] req_addr_i,
  input  logic [2*DATA_W-1:0] req_w_data_i,
  input  logic [7:0]          req_w_mask_i,
  output logic [2*DATA_W-1:0] req_r_data_o,
  output logic [1:0]          req_busy_o,
  output logic [1:0]          req_done_o,
  output logic [1:0]          mem_rw_flag_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_w_data_o,
  output logic [3:0]          mem_w_mask_o,
  input  logic [DATA_W-1:0]   mem_r_data_i,
  input  logic                mem_busy_i,
  input  logic                mem_done_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_next_s;

  logic [1:0]          req_valid_s;
  logic                grant_sel_s;
  logic                grant_take_s;

  logic                grant_r;
  logic [1:0]          lat_flag_r;
  logic [ADDR_W-1:0]   lat_addr_r;
  logic [DATA_W-1:0]   lat_w_data_r;
  logic [3:0]          lat_w_mask_r;
  logic [DATA_W-1:0]   resp_data_r;

`ifdef MEM_ARB_RR_EN
  logic                last_grant_r;
`endif

  // A channel requests only with a read (01) or write (10); 11 counts as idle.
  function automatic logic flag_is_req(input logic [1:0] flag);
    return (flag == 2'b01) || (flag == 2'b10);
  endfunction

  // Decode per-channel request validity.
  always_comb begin
    req_valid_s    = 2'b00;
    req_valid_s[0] = flag_is_req(req_rw_flag_i[1:0]);
    req_valid_s[1] = flag_is_req(req_rw_flag_i[3:2]);
  end

  // Pick the winning channel; only consulted in IDLE.
  always_comb begin
    grant_sel_s = 1'b0;
    case (req_valid_s)
      2'b01:   grant_sel_s = 1'b0;
      2'b10:   grant_sel_s = 1'b1;
`ifdef MEM_ARB_RR_EN
      2'b11:   grant_sel_s = ~last_grant_r;
`else
      2'b11:   grant_sel_s = 1'b1;
`endif
      default: grant_sel_s = 1'b0;
    endcase
  end

  // A grant is taken in IDLE whenever any channel requests.
  always_comb begin
    grant_take_s = 1'b0;
    if (state_r == ST_IDLE) begin
      grant_take_s = |req_valid_s;
    end else begin
      grant_take_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_take_s) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!mem_busy_i) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (mem_done_i) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Capture the winner's request on the IDLE->ISSUE transition; these
  // registers directly drive the downstream address/data/mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r      <= 1'b0;
      lat_flag_r   <= 2'b00;
      lat_addr_r   <= {ADDR_W{1'b0}};
      lat_w_data_r <= {DATA_W{1'b0}};
      lat_w_mask_r <= 4'b0000;
    end else if (grant_take_s) begin
      grant_r      <= grant_sel_s;
      lat_flag_r   <= grant_sel_s ? req_rw_flag_i[3:2] : req_rw_flag_i[1:0];
      lat_addr_r   <= grant_sel_s ? req_addr_i[2*ADDR_W-1:ADDR_W]
                                  : req_addr_i[ADDR_W-1:0];
      lat_w_data_r <= grant_sel_s ? req_w_data_i[2*DATA_W-1:DATA_W]
                                  : req_w_data_i[DATA_W-1:0];
      lat_w_mask_r <= grant_sel_s ? req_w_mask_i[7:4] : req_w_mask_i[3:0];
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember the most recent grant so the other channel wins the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (grant_take_s) begin
      last_grant_r <= grant_sel_s;
    end
  end
`endif

  // Response register: downstream read data captured on completion in WAIT.
  // Writes capture it too; the requester simply ignores it.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_data_r <= {DATA_W{1'b0}};
    end else if ((state_r == ST_WAIT) && mem_done_i) begin
      resp_data_r <= mem_r_data_i;
    end
  end

  // Output decode. The command flag is gated by mem_busy_i in the same cycle
  // so it is nonzero only in the single accepted ISSUE cycle.
  always_comb begin
    mem_rw_flag_o = 2'b00;
    req_done_o    = 2'b00;
    req_r_data_o  = {(2*DATA_W){1'b0}};
    req_busy_o    = {2{state_r != ST_IDLE}};
    case (state_r)
      ST_ISSUE: begin
        if (!mem_busy_i) begin
          mem_rw_flag_o = lat_flag_r;
        end else begin
          mem_rw_flag_o = 2'b00;
        end
      end
      ST_RESP: begin
        if (grant_r) begin
          req_done_o   = 2'b10;
          req_r_data_o = {resp_data_r, {DATA_W{1'b0}}};
        end else begin
          req_done_o   = 2'b01;
          req_r_data_o = {{DATA_W{1'b0}}, resp_data_r};
        end
      end
      default: begin
        mem_rw_flag_o = 2'b00;
      end
    endcase
  end

  assign mem_addr_o   = lat_addr_r;
  assign mem_w_data_o = lat_w_data_r;
  assign mem_w_mask_o = lat_w_mask_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Randomized bench. Two requester models and a memory model drive the
// arbiter; a transaction-level reference tracks, by cycle number, when the
// current transaction was granted, issued and completed, and predicts every
// output each cycle from those timestamps and the arbitration rule.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_rw_flag_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_w_data_i;
  logic [7:0]  req_w_mask_i;
  logic [63:0] req_r_data_o;
  logic [1:0]  req_busy_o;
  logic [1:0]  req_done_o;
  logic [1:0]  mem_rw_flag_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_w_data_o;
  logic [3:0]  mem_w_mask_o;
  logic [31:0] mem_r_data_i;
  logic        mem_busy_i;
  logic        mem_done_i;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_rw_flag_i (req_rw_flag_i),
    .req_addr_i    (req_addr_i),
    .req_w_data_i  (req_w_data_i),
    .req_w_mask_i  (req_w_mask_i),
    .req_r_data_o  (req_r_data_o),
    .req_busy_o    (req_busy_o),
    .req_done_o    (req_done_o),
    .mem_rw_flag_o (mem_rw_flag_o),
    .mem_addr_o    (mem_addr_o),
    .mem_w_data_o  (mem_w_data_o),
    .mem_w_mask_o  (mem_w_mask_o),
    .mem_r_data_i  (mem_r_data_i),
    .mem_busy_i    (mem_busy_i),
    .mem_done_i    (mem_done_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  int cyc;

  // Requester state
  logic [1:0]  q_flag [2];
  logic [31:0] q_addr [2];
  logic [31:0] q_wd   [2];
  logic [3:0]  q_mask [2];
  bit          hold   [2];

  // Reference model: timestamps of the current transaction
  bit          act;
  int          iss_c;
  int          done_c;
  int          free_c;
  bit          win;
  bit          last;
  logic [1:0]  m_flag;
  logic [31:0] m_addr;
  logic [31:0] m_wd;
  logic [3:0]  m_mask;
  logic [31:0] m_rd;

  bit          do_rst;
  bit          spur;
  int          n_rst;
  int          n_txn;
  bit          resp;

  logic [1:0]  e_flag;
  logic [1:0]  e_done;
  logic [63:0] e_rdata;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      if (n_err <= 20)
        $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit is_req(input logic [1:0] f);
    return (f == 2'b01) || (f == 2'b10);
  endfunction

  initial begin
    n_cmp = 0; n_err = 0; n_rst = 0; n_txn = 0; spur = 1'b0;
    rst = 1'b1;
    req_rw_flag_i = 4'h0; req_addr_i = 64'h0; req_w_data_i = 64'h0;
    req_w_mask_i = 8'h0; mem_r_data_i = 32'h0; mem_busy_i = 1'b0; mem_done_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      q_flag[c] = 2'b00; q_addr[c] = 32'h0; q_wd[c] = 32'h0; q_mask[c] = 4'h0; hold[c] = 1'b0;
    end
    act = 1'b0; iss_c = -1; done_c = -1; free_c = 0; win = 1'b0; last = 1'b1;
    m_flag = 2'b00; m_addr = 32'h0; m_wd = 32'h0; m_mask = 4'h0; m_rd = 32'h0;
    repeat (2) @(posedge clk);

    cyc = 0;
    while (cyc < 4000) begin
      @(negedge clk);

      // Occasional reset while a transaction waits for memory completion.
      do_rst = 1'b0;
      if (act && iss_c >= 0 && done_c < 0 && n_rst < 8 && $urandom_range(0, 31) == 0)
        do_rst = 1'b1;

      // Requesters: hold a valid request until its done has been seen.
      for (int c = 0; c < 2; c++) begin
        if (do_rst) begin
          q_flag[c] = 2'b00; hold[c] = 1'b0;
        end else if (!hold[c]) begin
          if ($urandom_range(0, 1) == 1) begin
            q_flag[c] = 2'($urandom_range(0, 3));
            q_addr[c] = $urandom;
            q_wd[c]   = $urandom;
            q_mask[c] = 4'($urandom_range(0, 15));
          end
          hold[c] = is_req(q_flag[c]);
        end else if (act && (int'(win) == c) && $urandom_range(0, 7) == 0) begin
          // Misbehaving requester after grant: the latched copy must win.
          q_addr[c] = $urandom;
          q_wd[c]   = $urandom;
        end
      end

      // Memory side.
      mem_busy_i   = ($urandom_range(0, 2) == 0);
      mem_r_data_i = $urandom;
      mem_done_i   = 1'b0;
      if (spur) begin
        mem_done_i = 1'b1;
        spur = 1'b0;
      end else if (act && iss_c >= 0 && done_c < 0) begin
        mem_done_i = ($urandom_range(0, 2) == 0);
      end else begin
        mem_done_i = ($urandom_range(0, 15) == 0);
      end
      if (do_rst) begin
        spur = 1'b1;
        n_rst++;
      end
      rst = do_rst;

      req_rw_flag_i = {q_flag[1], q_flag[0]};
      req_addr_i    = {q_addr[1], q_addr[0]};
      req_w_data_i  = {q_wd[1], q_wd[0]};
      req_w_mask_i  = {q_mask[1], q_mask[0]};

      #1;
      // Expected outputs for this cycle.
      resp    = act && (done_c >= 0) && (cyc == done_c + 1);
      e_flag  = (act && iss_c < 0 && !mem_busy_i) ? m_flag : 2'b00;
      e_done  = resp ? (win ? 2'b10 : 2'b01) : 2'b00;
      e_rdata = resp ? (win ? {m_rd, 32'h0} : {32'h0, m_rd}) : 64'h0;
      check_val("mem_rw_flag", {62'h0, mem_rw_flag_o}, {62'h0, e_flag});
      check_val("mem_addr",    {32'h0, mem_addr_o},    {32'h0, m_addr});
      check_val("mem_w_data",  {32'h0, mem_w_data_o},  {32'h0, m_wd});
      check_val("mem_w_mask",  {60'h0, mem_w_mask_o},  {60'h0, m_mask});
      check_val("req_busy",    {62'h0, req_busy_o},    act ? 64'h3 : 64'h0);
      check_val("req_done",    {62'h0, req_done_o},    {62'h0, e_done});
      check_val("req_r_data",  req_r_data_o,           e_rdata);

      // Advance the reference to the next cycle.
      if (do_rst) begin
        act = 1'b0; iss_c = -1; done_c = -1; free_c = cyc + 1; last = 1'b1;
        m_flag = 2'b00; m_addr = 32'h0; m_wd = 32'h0; m_mask = 4'h0;
      end else if (act) begin
        if (iss_c < 0) begin
          if (!mem_busy_i) iss_c = cyc;
        end else if (done_c < 0) begin
          if (mem_done_i) begin
            done_c = cyc;
            m_rd   = mem_r_data_i;
          end
        end else begin
          act = 1'b0;
          hold[win] = 1'b0;
          free_c = cyc + 1;
          n_txn++;
        end
      end else if (cyc >= free_c && (is_req(q_flag[0]) || is_req(q_flag[1]))) begin
        if (is_req(q_flag[0]) && is_req(q_flag[1])) begin
`ifdef MEM_ARB_RR_EN
          win = ~last;
`else
          win = 1'b1;
`endif
        end else begin
          win = is_req(q_flag[1]);
        end
        last   = win;
        act    = 1'b1;
        iss_c  = -1;
        done_c = -1;
        m_flag = q_flag[win];
        m_addr = q_addr[win];
        m_wd   = q_wd[win];
        m_mask = q_mask[win];
      end
      cyc++;
    end

    check_val("txn_progress", {63'h0, (n_txn > 100)}, 64'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
